latch_bank_write_ctrl: RTL and testbench
========================================

Name: latch_bank_write_ctrl

Overview:
- Sequences write transactions into a bank of NLATCH level-sensitive D latches of WIDTH bits each.
- Each latch has one D input and one control (C) input; the D bus is shared and each latch has its own C.
- Arbitrates round-robin among NREQ requesters.
- Drives the shared D bus and the one-hot latch-enable vector with explicit setup, open and hold phases, so that D is stable for the whole time any C is high.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, latch data width.
- NLATCH, 8, number of latches in the bank (2..16); AW = clog2(NLATCH) is a derived localparam.
- SETUP_CYCLES, 1, cycles D is driven before C rises (1..15).
- OPEN_CYCLES, 1, cycles C is held high (1..15).
- HOLD_CYCLES, 1, cycles D is held after C falls (1..15).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester write request (level).
- req_addr  in  NREQ*AW  packed target latch index; requester i uses slice [i*AW +: AW].
- req_data  in  NREQ*WIDTH  packed write data; requester i uses slice [i*WIDTH +: WIDTH].
- ack  out  NREQ  one-hot, 1-cycle pulse: transaction of that requester is complete.
- err  out  1  1-cycle pulse coincident with ack when the captured address is >= NLATCH.
- latch_d  out  WIDTH  shared data bus to all latch D inputs.
- latch_c  out  NLATCH  one-hot latch control (C) vector.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State = IDLE, rr pointer = 0, phase counter = 0.
  - ack = 0, err = 0, latch_c = 0, latch_d = 0, busy = 0.
  - Reset asserted mid-transaction drops latch_c to 0 immediately; the latches keep whatever value they held.
- All outputs are registered; latch_c must never glitch.
- FSM states: IDLE, SETUP, OPEN, HOLD, DONE.
- IDLE:
  - If any req is high at a clk edge, the winner is captured: grant index, addr slice and data slice.
  - latch_d is loaded with the captured data; next state = SETUP.
  - If no req is high, stay in IDLE.
- SETUP: lasts SETUP_CYCLES; latch_d stable; latch_c = 0.
- OPEN:
  - Lasts OPEN_CYCLES; latch_c[addr] = 1, all other bits 0.
  - If addr >= NLATCH, latch_c stays all-0.
- HOLD: lasts HOLD_CYCLES; latch_c = 0; latch_d unchanged.
- DONE:
  - Lasts 1 cycle; ack[grant] = 1; err = (addr >= NLATCH).
  - rr pointer = grant+1 mod NREQ; next state = IDLE.
- latch_d changes only on the IDLE->SETUP transition, and otherwise holds its last value, including while idle.
- Latency: req sampled at edge k -> latch_c high during cycles k+1+S .. k+S+O -> ack high in cycle k+1+S+O+H.
  - With defaults, ack occupies the 4th cycle after the sampling edge.
- Throughput: one transaction per S+O+H+2 cycles, because DONE always returns to IDLE.
- Arbitration:
  - Round-robin search starting at the rr pointer, using the first req set.
  - After reset, requester 0 has the highest priority.
- Requester protocol:
  - A requester holds req, addr and data until it sees its ack, then deasserts req for at least one cycle or presents a new transaction.
  - Addr/data are captured at grant; changes after the grant are ignored.
  - req dropping mid-transaction does not abort; the transaction completes and ack still pulses.
- The phase counter is 4 bits. It loads phase_length-1 on entry to each phase, and the phase ends when the counter reaches 0.
- The same-cycle request that wins in IDLE is the only one served; other reqs stay pending. There is no queueing beyond the req level.

Decomposition:
- Shared package latch_ctrl_pkg:
  - State enum: IDLE, SETUP, OPEN, HOLD, DONE.
  - Counter width constant: 4.
  - clog2-based address-width function.
- Sub-module rr_arbiter:
  - Parameter NREQ.
  - Inputs: req, ptr.
  - Outputs: one-hot gnt, valid.
  - Purely combinational, so it can be reused by other bank controllers.
- The FSM, capture registers, counter and output registers live in latch_bank_write_ctrl.

Test Plan:
- Reset then single write (defaults): req[2]=1, addr=5, data=8'hA5.
  - latch_d=A5 from cycle 1.
  - latch_c=8'b0010_0000 in cycle 2 only.
  - ack=4'b0100 in cycle 4; busy high in cycles 1-4.
- Contention:
  - req=4'b1111 held continuously after reset -> grants in order 0,1,2,3,0.
  - Consecutive acks are 5 cycles apart.
  - latch_c bits match each requester's addr.
- Timing parameters SETUP=2, OPEN=3, HOLD=2:
  - latch_c high for exactly 3 cycles, with D stable for 2 cycles before and 2 cycles after.
  - ack arrives 8 cycles after the sampling edge.
- Out-of-range address (NLATCH=6): addr=7.
  - latch_c stays 0 for the whole transaction.
  - ack and err pulse together.
  - The next legal write behaves normally.
- Mid-operation disturbances:
  - rst_n pulled low during OPEN -> latch_c, ack, busy = 0 asynchronously.
  - After release, a fresh req is served starting from requester 0.
  - req deasserted during SETUP -> the transaction still completes with ack.

Source files
------------

// File: rtl/latch_bank_write_ctrl_pkg.sv
// Shared definitions for the latch-bank write controller family.
//   state_t     : controller FSM states
//   CNT_W       : width of the phase down-counter
//   addr_width  : clog2-based index width (never less than 1 bit)
package latch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        OPEN  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int CNT_W = 4;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/latch_bank_write_ctrl_if.sv
// Requester/latch-bank bus of the latch-bank write controller.
//   req       : per-requester write request (level)
//   req_addr  : packed target latch indices, requester i at [i*AW +: AW]
//   req_data  : packed write data, requester i at [i*WIDTH +: WIDTH]
//   ack       : one-hot completion pulse
//   err       : completion pulse flagging an out-of-range address
//   latch_d   : shared D bus to every latch
//   latch_c   : one-hot latch control vector
//   busy      : controller not idle
// master = requester/bench side, slave = controller side.
interface latch_bank_write_ctrl_if #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 8,
    parameter int NLATCH = 8
);
    localparam int AW = latch_ctrl_pkg::addr_width(NLATCH);

    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       ack;
    logic                  err;
    logic [WIDTH-1:0]      latch_d;
    logic [NLATCH-1:0]     latch_c;
    logic                  busy;

    modport master (
        output req, req_addr, req_data,
        input  ack, err, latch_d, latch_c, busy
    );

    modport slave (
        input  req, req_addr, req_data,
        output ack, err, latch_d, latch_c, busy
    );

endinterface

// File: rtl/latch_bank_write_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : index of the highest-priority requester
//   gnt   : one-hot grant of the first set request at or after ptr
//   valid : any request set
module rr_arbiter
    import latch_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int PW  = addr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic            valid
);

    int w_idx;

    // Walk the requesters in priority order; the inner loop keeps every
    // vector access at a constant index.
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        w_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!valid && (j == w_idx) && req[j]) begin
                    gnt[j] = 1'b1;
                    valid  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/latch_bank_write_ctrl.sv
// Write sequencer for a bank of level-sensitive D latches sharing one D bus.
// Arbitrates requesters round-robin, then drives D through setup, open and
// hold phases so D is stable whenever any latch C input is high.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : requester side (req/addr/data/ack/err/busy) and latch side
//            (latch_d, latch_c); all outputs come straight from flops.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a request; winner captured on the leaving edge
// SETUP | D driven, all C low, SETUP_CYCLES long
// OPEN  | C[addr] high (none if addr out of range), OPEN_CYCLES long
// HOLD  | D held, all C low, HOLD_CYCLES long
// DONE  | one cycle: ack[grant] (and err) pulse, pointer advances
module latch_bank_write_ctrl
    import latch_ctrl_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int WIDTH        = 8,
    parameter int NLATCH       = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int OPEN_CYCLES  = 1,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    latch_bank_write_ctrl_if.slave  bus
);

    localparam int AW = addr_width(NLATCH);
    localparam int PW = addr_width(NREQ);

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] OPEN_LOAD  = CNT_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [AW:0]      NL_LIMIT   = (AW + 1)'(NLATCH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      w_ptr_nxt;
    logic [NREQ-1:0]    r_gnt;
    logic [PW-1:0]      r_gidx;
    logic [AW-1:0]      r_addr;
    logic [WIDTH-1:0]   r_latch_d;
    logic [NLATCH-1:0]  r_latch_c;
    logic [NREQ-1:0]    r_ack;
    logic               r_err;
    logic               r_busy;

    logic [NREQ-1:0]    w_gnt;
    logic               w_valid;
    logic               w_capture;
    logic [PW-1:0]      w_gidx;
    logic [AW-1:0]      w_addr;
    logic [WIDTH-1:0]   w_data;
    logic [NLATCH-1:0]  w_dec;
    logic               w_oor;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req   (bus.req),
        .ptr   (r_ptr),
        .gnt   (w_gnt),
        .valid (w_valid)
    );

    assign w_capture = (r_state == IDLE) && w_valid;

    // Select the winner's index, address and data (one-hot AND-OR mux).
    always_comb begin
        w_gidx = '0;
        w_addr = '0;
        w_data = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_gnt[j]) begin
                w_gidx = PW'(j);
                w_addr = bus.req_addr[j*AW +: AW];
                w_data = bus.req_data[j*WIDTH +: WIDTH];
            end
        end
    end

    // An out-of-range address decodes to no bit at all, so C stays low.
    always_comb begin
        w_dec = '0;
        for (int i = 0; i < NLATCH; i++) begin
            w_dec[i] = (r_addr == AW'(i));
        end
    end

    assign w_oor     = ({1'b0, r_addr} >= NL_LIMIT);
    assign w_ptr_nxt = (r_gidx == PW'(NREQ - 1)) ? '0 : r_gidx + PW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_state_nxt = SETUP;
                    w_cnt_nxt   = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = OPEN;
                    w_cnt_nxt   = OPEN_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            OPEN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = HOLD_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are computed from the next state so each one is a plain flop
    // that is already valid in the cycle its state is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_gidx    <= '0;
            r_addr    <= '0;
            r_latch_d <= '0;
            r_latch_c <= '0;
            r_ack     <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_latch_c <= (w_state_nxt == OPEN) ? w_dec : '0;
            r_ack     <= (w_state_nxt == DONE) ? r_gnt : '0;
            r_err     <= (w_state_nxt == DONE) && w_oor;
            if (w_capture) begin
                r_gnt     <= w_gnt;
                r_gidx    <= w_gidx;
                r_addr    <= w_addr;
                r_latch_d <= w_data;
            end
            if (r_state == DONE) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign bus.ack     = r_ack;
    assign bus.err     = r_err;
    assign bus.latch_d = r_latch_d;
    assign bus.latch_c = r_latch_c;
    assign bus.busy    = r_busy;

endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
// Directed bench for latch_bank_write_ctrl with three configurations:
//   u_dut0 : defaults (S=O=H=1, NLATCH=8)
//   u_dut1 : S=2, O=3, H=2
//   u_dut2 : NLATCH=6 (address 6/7 out of range)
// Cycle n is the clock period after posedge n-1, where posedge 0 samples req.
module tb_latch_bank_write_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    int         t2_addr [4];
    logic [7:0] t2_data [4];
    int         n_ack;
    int         n_open;

    always #5 clk = ~clk;

    latch_bank_write_ctrl_if #(.NREQ(4), .WIDTH(8), .NLATCH(8)) b0 ();
    latch_bank_write_ctrl_if #(.NREQ(4), .WIDTH(8), .NLATCH(8)) b1 ();
    latch_bank_write_ctrl_if #(.NREQ(4), .WIDTH(8), .NLATCH(6)) b2 ();

    latch_bank_write_ctrl #(
        .NREQ(4), .WIDTH(8), .NLATCH(8),
        .SETUP_CYCLES(1), .OPEN_CYCLES(1), .HOLD_CYCLES(1)
    ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

    latch_bank_write_ctrl #(
        .NREQ(4), .WIDTH(8), .NLATCH(8),
        .SETUP_CYCLES(2), .OPEN_CYCLES(3), .HOLD_CYCLES(2)
    ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    latch_bank_write_ctrl #(
        .NREQ(4), .WIDTH(8), .NLATCH(6),
        .SETUP_CYCLES(1), .OPEN_CYCLES(1), .HOLD_CYCLES(1)
    ) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected normal completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst_n = 1'b1;
        b0.req = '0; b0.req_addr = '0; b0.req_data = '0;
        b1.req = '0; b1.req_addr = '0; b1.req_data = '0;
        b2.req = '0; b2.req_addr = '0; b2.req_data = '0;
        t2_addr = '{1, 3, 6, 0};
        t2_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        #1 rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_busy",    b0.busy,    0);
        check_val("rst_latch_c", b0.latch_c, 0);
        check_val("rst_latch_d", b0.latch_d, 0);
        check_val("rst_ack",     b0.ack,     0);
        check_val("rst_err",     b0.err,     0);
        check_val("rst_busy1",   b1.busy,    0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: single write, requester 2, addr 5, data A5
        b0.req_addr[6 +: 3]  = 3'd5;
        b0.req_data[16 +: 8] = 8'hA5;
        b0.req = 4'b0100;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check_val($sformatf("t1_c%0d_latch_d", c), b0.latch_d, 32'hA5);
            check_val($sformatf("t1_c%0d_latch_c", c), b0.latch_c, (c == 2) ? 32'h20 : 32'h0);
            check_val($sformatf("t1_c%0d_ack", c), b0.ack, (c == 4) ? 32'h4 : 32'h0);
            check_val($sformatf("t1_c%0d_busy", c), b0.busy, (c >= 1 && c <= 4) ? 32'h1 : 32'h0);
            if (c == 4) b0.req = '0;
        end

        // T2: contention from a fresh reset, grants 0,1,2,3,0 every 5 cycles
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            b0.req_addr[j*3 +: 3] = 3'(t2_addr[j]);
            b0.req_data[j*8 +: 8] = t2_data[j];
        end
        b0.req = 4'b1111;
        @(posedge clk);
        n_ack  = 0;
        n_open = 0;
        for (int c = 1; c <= 40 && n_ack < 5; c++) begin
            @(negedge clk);
            if (b0.latch_c != '0) begin
                check_val($sformatf("t2_open%0d_latch_c", n_open), b0.latch_c,
                          32'(1) << t2_addr[n_open % 4]);
                check_val($sformatf("t2_open%0d_latch_d", n_open), b0.latch_d,
                          32'(t2_data[n_open % 4]));
                check_val($sformatf("t2_open%0d_cycle", n_open), c, 2 + 5 * n_open);
                n_open++;
            end
            if (b0.ack != '0) begin
                check_val($sformatf("t2_ack%0d_value", n_ack), b0.ack, 32'(1) << (n_ack % 4));
                check_val($sformatf("t2_ack%0d_cycle", n_ack), c, 4 + 5 * n_ack);
                n_ack++;
            end
        end
        b0.req = '0;
        check_val("t2_ack_count",  n_ack,  5);
        check_val("t2_open_count", n_open, 5);
        @(negedge clk);

        // T3: S=2, O=3, H=2, requester 1, addr 4, data 5A
        b1.req_addr[3 +: 3] = 3'd4;
        b1.req_data[8 +: 8] = 8'h5A;
        b1.req = 4'b0010;
        @(posedge clk);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check_val($sformatf("t3_c%0d_latch_d", c), b1.latch_d, 32'h5A);
            check_val($sformatf("t3_c%0d_latch_c", c), b1.latch_c, (c >= 3 && c <= 5) ? 32'h10 : 32'h0);
            check_val($sformatf("t3_c%0d_ack", c), b1.ack, (c == 8) ? 32'h2 : 32'h0);
            check_val($sformatf("t3_c%0d_busy", c), b1.busy, (c <= 8) ? 32'h1 : 32'h0);
            if (c == 8) b1.req = '0;
        end

        // T4: NLATCH=6, addr 7 is out of range, then a legal write to addr 5
        b2.req_addr[0 +: 3] = 3'd7;
        b2.req_data[0 +: 8] = 8'hC3;
        b2.req = 4'b0001;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check_val($sformatf("t4a_c%0d_latch_c", c), b2.latch_c, 0);
            check_val($sformatf("t4a_c%0d_ack", c), b2.ack, (c == 4) ? 32'h1 : 32'h0);
            check_val($sformatf("t4a_c%0d_err", c), b2.err, (c == 4) ? 32'h1 : 32'h0);
            if (c == 4) b2.req = '0;
        end
        b2.req_addr[0 +: 3] = 3'd5;
        b2.req_data[0 +: 8] = 8'h3C;
        b2.req = 4'b0001;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check_val($sformatf("t4b_c%0d_latch_c", c), b2.latch_c, (c == 2) ? 32'h20 : 32'h0);
            check_val($sformatf("t4b_c%0d_latch_d", c), b2.latch_d, 32'h3C);
            check_val($sformatf("t4b_c%0d_ack", c), b2.ack, (c == 4) ? 32'h1 : 32'h0);
            check_val($sformatf("t4b_c%0d_err", c), b2.err, 0);
            if (c == 4) b2.req = '0;
        end

        // T5: reset during OPEN, then priority restarts at requester 0
        b0.req_addr[9 +: 3]  = 3'd2;
        b0.req_data[24 +: 8] = 8'h77;
        b0.req = 4'b1000;
        @(posedge clk);
        repeat (2) @(negedge clk);
        check_val("t5_open_latch_c", b0.latch_c, 32'h04);
        #2 rst_n = 1'b0;
        #1;
        check_val("t5_rst_latch_c", b0.latch_c, 0);
        check_val("t5_rst_ack",     b0.ack,     0);
        check_val("t5_rst_busy",    b0.busy,    0);
        b0.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        b0.req_addr[0 +: 3]  = 3'd1;
        b0.req_data[0 +: 8]  = 8'hE1;
        b0.req_addr[9 +: 3]  = 3'd6;
        b0.req_data[24 +: 8] = 8'hE3;
        b0.req = 4'b1001;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check_val($sformatf("t5_c%0d_latch_c", c), b0.latch_c, (c == 2) ? 32'h02 : 32'h0);
            check_val($sformatf("t5_c%0d_latch_d", c), b0.latch_d, 32'hE1);
            check_val($sformatf("t5_c%0d_ack", c), b0.ack, (c == 4) ? 32'h1 : 32'h0);
            if (c == 4) b0.req = '0;
        end

        // T6: req dropped during SETUP still completes
        b0.req_addr[6 +: 3]  = 3'd3;
        b0.req_data[16 +: 8] = 8'h99;
        b0.req = 4'b0100;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check_val($sformatf("t6_c%0d_latch_c", c), b0.latch_c, (c == 2) ? 32'h08 : 32'h0);
            check_val($sformatf("t6_c%0d_latch_d", c), b0.latch_d, 32'h99);
            check_val($sformatf("t6_c%0d_ack", c), b0.ack, (c == 4) ? 32'h4 : 32'h0);
            if (c == 1) b0.req = '0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
